// File: rtl/exe_hazard_fwd_ctrl_pkg.sv
// Shared types and constants for the EXE-stage hazard/forwarding controller:
// forwarding-select encodings, the tracker entry record and matching helpers.
package exe_hazard_fwd_ctrl_pkg;

  localparam int ARM_REG_AW = 4;
  localparam int ARM_SEL_W  = 2;

  localparam logic [1:0] FU_SEL_RN  = 2'd0;
  localparam logic [1:0] FU_SEL_MEM = 2'd1;
  localparam logic [1:0] FU_SEL_WB  = 2'd2;

  typedef struct packed {
    logic                  valid;
    logic [ARM_REG_AW-1:0] dest;
    logic                  wb_en;
    logic                  mem_r;
  } trk_entry_t;

  localparam trk_entry_t TRK_EMPTY = '{valid: 1'b0, dest: {ARM_REG_AW{1'b0}}, wb_en: 1'b0, mem_r: 1'b0};

  // An in-flight entry supplies register s only if it is real and writes back.
  function automatic logic entry_match(trk_entry_t e, logic [ARM_REG_AW-1:0] s);
    return e.valid & e.wb_en & (e.dest == s);
  endfunction

  function automatic logic [1:0] pick_sel(logic hit_exe, logic hit_mem);
    logic [1:0] sel;
    sel = FU_SEL_RN;
    if (hit_exe) begin
      sel = FU_SEL_MEM;
    end else if (hit_mem) begin
      sel = FU_SEL_WB;
    end else begin
      sel = FU_SEL_RN;
    end
    return sel;
  endfunction

endpackage

// File: rtl/exe_hazard_fwd_ctrl_if.sv
// Control/observation bundle between the ID/EXE pipeline logic and the
// hazard/forwarding controller.
interface exe_hazard_fwd_ctrl_if
  import exe_hazard_fwd_ctrl_pkg::*;
#(
  parameter int REG_AW = ARM_REG_AW,
  parameter int SEL_W  = ARM_SEL_W
) ();

  logic              freeze;
  logic              flush;
  logic              fwd_en;
  logic              id_valid;
  logic [REG_AW-1:0] id_src1;
  logic [REG_AW-1:0] id_src2;
  logic              id_two_src;
  logic [REG_AW-1:0] id_dest;
  logic              id_wb_en;
  logic              id_mem_r_en;
  logic [SEL_W-1:0]  fu_sel_src1;
  logic [SEL_W-1:0]  fu_sel_src2;
  logic              hazard_stall;
  // Read-only view of the tracker contents.
  trk_entry_t        trk_exe;
  trk_entry_t        trk_mem;
  trk_entry_t        trk_wb;

  modport master (
    output freeze, flush, fwd_en, id_valid, id_src1, id_src2, id_two_src,
           id_dest, id_wb_en, id_mem_r_en,
    input  fu_sel_src1, fu_sel_src2, hazard_stall, trk_exe, trk_mem, trk_wb
  );

  modport slave (
    input  freeze, flush, fwd_en, id_valid, id_src1, id_src2, id_two_src,
           id_dest, id_wb_en, id_mem_r_en,
    output fu_sel_src1, fu_sel_src2, hazard_stall, trk_exe, trk_mem, trk_wb
  );

endinterface

// File: rtl/exe_hazard_fwd_ctrl_hazard_tracker_stage.sv
// One tracker slot: loads its predecessor on advance, may be forced to a
// bubble, and holds otherwise.
module hazard_tracker_stage
  import exe_hazard_fwd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       bubble,
  input  trk_entry_t entry_in,
  output trk_entry_t entry_q
);

  // Slot register; reset and bubble both leave an invalid entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= TRK_EMPTY;
    end else if (advance) begin
      if (bubble) begin
        entry_q <= TRK_EMPTY;
      end else begin
        entry_q <= entry_in;
      end
    end else begin
      entry_q <= entry_q;
    end
  end

endmodule

// File: rtl/exe_hazard_fwd_ctrl.sv
// EXE operand-source sequencer: tracks in-flight writers in EXE/MEM/WB and
// produces registered forwarding selects plus the IF/ID hazard stall.
module exe_hazard_fwd_ctrl
  import exe_hazard_fwd_ctrl_pkg::*;
#(
  parameter int REG_AW = ARM_REG_AW,
  parameter int SEL_W  = ARM_SEL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  exe_hazard_fwd_ctrl_if.slave  bus
);

  trk_entry_t        exe_q;
  trk_entry_t        mem_q;
  trk_entry_t        wb_q;
  trk_entry_t        id_entry_s;
  logic [REG_AW-1:0] src1_s;
  logic [REG_AW-1:0] src2_s;
  logic              advance_s;
  logic              hit_exe1_s;
  logic              hit_exe2_s;
  logic              hit_mem1_s;
  logic              hit_mem2_s;
  logic              stall_raw_s;
  logic              stall_s;
  logic              id_bubble_s;
  logic [SEL_W-1:0]  sel1_s;
  logic [SEL_W-1:0]  sel2_s;
  logic [SEL_W-1:0]  sel1_r;
  logic [SEL_W-1:0]  sel2_r;

  assign advance_s  = ~bus.freeze;
  assign src1_s     = bus.id_src1;
  assign src2_s     = bus.id_src2;
  assign id_entry_s = '{valid: bus.id_valid, dest: bus.id_dest,
                        wb_en: bus.id_wb_en, mem_r: bus.id_mem_r_en};

  assign hit_exe1_s = entry_match(exe_q, src1_s);
  assign hit_exe2_s = bus.id_two_src & entry_match(exe_q, src2_s);
  assign hit_mem1_s = entry_match(mem_q, src1_s);
  assign hit_mem2_s = bus.id_two_src & entry_match(mem_q, src2_s);

  // Forwarding only has to wait for a load still in EXE; stall-only mode waits
  // for any writer in EXE or MEM since the register file is write-before-read.
  always_comb begin
    stall_raw_s = 1'b0;
    if (bus.fwd_en) begin
      stall_raw_s = exe_q.mem_r & (hit_exe1_s | hit_exe2_s);
    end else begin
      stall_raw_s = hit_exe1_s | hit_exe2_s | hit_mem1_s | hit_mem2_s;
    end
  end

  assign stall_s     = bus.id_valid & ~bus.flush & stall_raw_s;
  assign id_bubble_s = stall_s | bus.flush | ~bus.id_valid;

  // Next selects; EXE hit wins over MEM hit (youngest writer).
  always_comb begin
    sel1_s = FU_SEL_RN;
    sel2_s = FU_SEL_RN;
    if (!id_bubble_s && bus.fwd_en) begin
      sel1_s = pick_sel(hit_exe1_s, hit_mem1_s);
      sel2_s = pick_sel(hit_exe2_s, hit_mem2_s);
    end else begin
      sel1_s = FU_SEL_RN;
      sel2_s = FU_SEL_RN;
    end
  end

  // Select registers move with the pipeline so they line up with EXE.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel1_r <= FU_SEL_RN;
      sel2_r <= FU_SEL_RN;
    end else if (advance_s) begin
      sel1_r <= sel1_s;
      sel2_r <= sel2_s;
    end else begin
      sel1_r <= sel1_r;
      sel2_r <= sel2_r;
    end
  end

  hazard_tracker_stage u_trk_exe (
    .clk      (clk),
    .rst      (rst),
    .advance  (advance_s),
    .bubble   (id_bubble_s),
    .entry_in (id_entry_s),
    .entry_q  (exe_q)
  );

  hazard_tracker_stage u_trk_mem (
    .clk      (clk),
    .rst      (rst),
    .advance  (advance_s),
    .bubble   (1'b0),
    .entry_in (exe_q),
    .entry_q  (mem_q)
  );

  hazard_tracker_stage u_trk_wb (
    .clk      (clk),
    .rst      (rst),
    .advance  (advance_s),
    .bubble   (1'b0),
    .entry_in (mem_q),
    .entry_q  (wb_q)
  );

  assign bus.fu_sel_src1  = sel1_r;
  assign bus.fu_sel_src2  = sel2_r;
  assign bus.hazard_stall = stall_s;
  assign bus.trk_exe      = exe_q;
  assign bus.trk_mem      = mem_q;
  assign bus.trk_wb       = wb_q;

endmodule
